// File: rtl/mips_mc_control.sv
// Multicycle MIPS control sequencer: a Moore FSM that steps a shared datapath
// through fetch/decode/execute/memory/write-back, counting retired instructions.
module mips_mc_control #(
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               BranchNe,
  output logic               ExtOp,
  output logic               JalEn,
  output logic               LuiEn,
  output logic               illegal,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB    = 4'd4,  S_MEMWR    = 4'd5,  S_RTYPE_EX = 4'd6, S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,  S_JUMP     = 4'd9,  S_IMM_EX = 4'd10, S_IMM_WB = 4'd11,
    S_JAL      = 4'd12, S_JR       = 4'd13, S_LUI_WB = 4'd14, S_ILLEGAL = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111, OP_LW   = 6'b100011, OP_SW   = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t             state_q;
  logic [COUNT_W-1:0] instret_q;
  logic               retire;

  // The datapath applies zero itself (PCWriteCond with BranchNe); the sequencer never needs it.
  logic unused_zero;
  assign unused_zero = zero;

  // ULA functs: add, sub, and, or, xor, nor, slt.
  function automatic logic alu_funct(input logic [5:0] fn);
    alu_funct = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) ||
                (fn == 6'h26) || (fn == 6'h27) || (fn == 6'h2A);
  endfunction

  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    state_t nxt;
    case (op)
      OP_LW, OP_SW:                      nxt = S_MEMADR;
      OP_RTYPE: begin
        if (fn == FN_JR)                 nxt = S_JR;
        else if (alu_funct(fn))          nxt = S_RTYPE_EX;
        else                             nxt = S_ILLEGAL;
      end
      OP_BEQ, OP_BNE:                    nxt = S_BRANCH;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: nxt = S_IMM_EX;
      OP_J:                              nxt = S_JUMP;
      OP_JAL:                            nxt = S_JAL;
      OP_LUI:                            nxt = S_LUI_WB;
      default:                           nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

  // An instruction retires on the edge leaving its last state; ILLEGAL never retires.
  assign retire = (state_q inside {S_MEMWB, S_RTYPE_WB, S_BRANCH, S_JUMP, S_IMM_WB,
                                   S_JAL, S_JR, S_LUI_WB}) ||
                  (state_q == S_MEMWR && mem_ready);

  // mem_ready: memory finished the access requested this cycle; only sampled in FETCH/MEMRD/MEMWR.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      if (retire) instret_q <= instret_q + COUNT_W'(1);
      case (state_q)
        S_FETCH:    if (mem_ready) state_q <= S_DECODE;
        S_DECODE:   state_q <= decode_next(opcode, funct);
        S_MEMADR:   state_q <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:    if (mem_ready) state_q <= S_MEMWB;
        S_MEMWR:    if (mem_ready) state_q <= S_FETCH;
        S_RTYPE_EX: state_q <= S_RTYPE_WB;
        S_IMM_EX:   state_q <= S_IMM_WB;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    IRWrite = 1'b0; MemtoReg = 1'b0; RegDst = 1'b0; RegWrite = 1'b0; ALUSrcA = 1'b0;
    ALUSrcB = 2'b00; ALUOp = 2'b00; PCSource = 2'b00; BranchNe = 1'b0; ExtOp = 1'b0;
    JalEn = 1'b0; LuiEn = 1'b0; illegal = 1'b0;
    // Reset silences every control so the memory sees an aborted access at once.
    if (!reset) begin
      ExtOp = 1'b1;
      case (state_q)
        S_FETCH:    begin MemRead = 1'b1; ALUSrcB = 2'b01; IRWrite = mem_ready; PCWrite = mem_ready; end
        S_DECODE:   ALUSrcB = 2'b11;
        S_MEMADR:   begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        S_MEMRD:    begin MemRead = 1'b1; IorD = 1'b1; end
        S_MEMWB:    begin RegWrite = 1'b1; MemtoReg = 1'b1; end
        S_MEMWR:    begin MemWrite = 1'b1; IorD = 1'b1; end
        S_RTYPE_EX: begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
        S_RTYPE_WB: begin RegWrite = 1'b1; RegDst = 1'b1; end
        S_BRANCH: begin
          ALUSrcA = 1'b1; ALUOp = 2'b01; PCWriteCond = 1'b1; PCSource = 2'b01;
          BranchNe = (opcode == OP_BNE);
        end
        S_JUMP:     begin PCWrite = 1'b1; PCSource = 2'b10; end
        S_IMM_EX, S_IMM_WB: begin
          if (state_q == S_IMM_EX) begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
          else RegWrite = 1'b1;
          if (opcode != OP_ADDI) begin ALUOp = 2'b11; ExtOp = 1'b0; end
        end
        S_JAL:      begin RegWrite = 1'b1; JalEn = 1'b1; PCWrite = 1'b1; PCSource = 2'b10; end
        S_JR:       begin PCWrite = 1'b1; PCSource = 2'b11; end
        S_LUI_WB:   begin RegWrite = 1'b1; LuiEn = 1'b1; end
        default:    illegal = 1'b1;
      endcase
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: acts as a variable-latency memory and checks each
// instruction's state walk, control word and retire count against a reference.
module tb_mips_mc_control;
  localparam int CW = 4;

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4, K_ADDI = 5, K_ANDI = 6;
  localparam int K_ORI = 7, K_XORI = 8, K_J = 9, K_JAL = 10, K_JR = 11, K_LUI = 12;
  localparam int K_ILLOP = 13, K_ILLFN = 14;

  logic          clock = 1'b0;
  logic          reset;
  logic [5:0]    opcode, funct;
  logic          zero, mem_ready;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst;
  logic          RegWrite, ALUSrcA, BranchNe, ExtOp, JalEn, LuiEn, illegal;
  logic [1:0]    ALUSrcB, ALUOp, PCSource;
  logic [3:0]    state;
  logic [CW-1:0] instret;
  logic [20:0]   obs_ctrl;

  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] model_instret;
  logic [3:0]    exp_q[$];
  logic          rdy_q[$];

  mips_mc_control #(.COUNT_W(CW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .BranchNe(BranchNe), .ExtOp(ExtOp),
    .JalEn(JalEn), .LuiEn(LuiEn), .illegal(illegal), .state(state), .instret(instret)
  );

  always #5 clock = ~clock;

  assign obs_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                     RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, BranchNe, ExtOp, JalEn,
                     LuiEn, illegal};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic alu_fn(input logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
  endfunction

  function automatic logic op_known(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E,
                      6'h0F, 6'h23, 6'h2B};
  endfunction

  // Expected control word for one cycle, read straight off the per-state output list.
  function automatic logic [20:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                           input logic [5:0] op);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, bne, ext, jal, lui, ill;
    logic [1:0] srcb, aluop, pcsrc;
    pcw = 0; pcwc = 0; iord = 0; mr = 0; mw = 0; irw = 0; m2r = 0; rdst = 0; rw = 0;
    srca = 0; bne = 0; ext = 1; jal = 0; lui = 0; ill = 0;
    srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00;
    case (st)
      4'd0:  begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      4'd1:  srcb = 2'b11;
      4'd2:  begin srca = 1; srcb = 2'b10; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iord = 1; end
      4'd6:  begin srca = 1; aluop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; bne = (op == 6'h05); end
      4'd9:  begin pcw = 1; pcsrc = 2'b10; end
      4'd10: begin srca = 1; srcb = 2'b10; if (op != 6'h08) begin aluop = 2'b11; ext = 0; end end
      4'd11: begin rw = 1; if (op != 6'h08) begin aluop = 2'b11; ext = 0; end end
      4'd12: begin rw = 1; jal = 1; pcw = 1; pcsrc = 2'b10; end
      4'd13: begin pcw = 1; pcsrc = 2'b11; end
      4'd14: begin rw = 1; lui = 1; end
      default: ill = 1;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc,
            bne, ext, jal, lui, ill};
  endfunction

  task automatic push_st(input logic [3:0] st);
    exp_q.push_back(st);
    rdy_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic push_wait(input logic [3:0] st, input int w);
    for (int i = 0; i < w; i++) begin exp_q.push_back(st); rdy_q.push_back(1'b0); end
    exp_q.push_back(st);
    rdy_q.push_back(1'b1);
  endtask

  // zsel: 0/1 force zero, 2 randomise it. abort_at: path index after which reset is raised.
  task automatic run_instr(input int kind, input logic [5:0] op, input logic [5:0] fn,
                           input int wf, input int wm, input int abort_at, input int zsel);
    int irw_cnt;
    exp_q.delete();
    rdy_q.delete();
    push_wait(4'd0, wf);
    push_st(4'd1);
    case (kind)
      K_R:                         begin push_st(4'd6); push_st(4'd7); end
      K_LW:                        begin push_st(4'd2); push_wait(4'd3, wm); push_st(4'd4); end
      K_SW:                        begin push_st(4'd2); push_wait(4'd5, wm); end
      K_BEQ, K_BNE:                push_st(4'd8);
      K_ADDI, K_ANDI, K_ORI, K_XORI: begin push_st(4'd10); push_st(4'd11); end
      K_J:                         push_st(4'd9);
      K_JAL:                       push_st(4'd12);
      K_JR:                        push_st(4'd13);
      K_LUI:                       push_st(4'd14);
      default:                     push_st(4'd15);
    endcase
    irw_cnt = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      if (i == 0) begin opcode = op; funct = fn; end
      zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : (zsel == 1);
      mem_ready = rdy_q[i];
      #1;
      check_eq("state", 32'(state), 32'(exp_q[i]));
      check_eq("ctrl", 32'(obs_ctrl), 32'(exp_ctrl(exp_q[i], rdy_q[i], op)));
      if (i == 0) check_eq("instret", 32'(instret), 32'(model_instret));
      if (exp_q[i] == 4'd8)
        check_eq("br_taken", 32'(PCWriteCond & (zero ^ BranchNe)),
                 32'((op == 6'h05) ? !zero : zero));
      irw_cnt += int'(IRWrite);
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        check_eq("abort_memwrite", 32'(MemWrite), 32'd0);
        check_eq("abort_state", 32'(state), 32'd0);
        check_eq("abort_instret", 32'(instret), 32'd0);
        model_instret = '0;
        return;
      end
    end
    check_eq("irw_once", 32'(irw_cnt), 32'd1);
    if (kind != K_ILLOP && kind != K_ILLFN) model_instret = model_instret + CW'(1);
  endtask

  task automatic run_random(input int n);
    int kind;
    logic [5:0] op, fn;
    logic [5:0] op_tab [13];
    op_tab = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E,
               6'h02, 6'h03, 6'h00, 6'h0F};
    for (int k = 0; k < n; k++) begin
      kind = $urandom_range(0, 14);
      fn = 6'($urandom_range(0, 63));
      if (kind <= K_LUI) op = op_tab[kind];
      else if (kind == K_ILLOP) begin
        do op = 6'($urandom_range(0, 63)); while (op_known(op));
      end else begin
        op = 6'h00;
        do fn = 6'($urandom_range(0, 63)); while (alu_fn(fn) || fn == 6'h08);
      end
      if (kind == K_R) begin
        do fn = 6'($urandom_range(0, 63)); while (!alu_fn(fn));
      end
      if (kind == K_JR) fn = 6'h08;
      run_instr(kind, op, fn, $urandom_range(0, 3), $urandom_range(0, 3), -1, 2);
    end
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    check_eq("first_fetch_memread", 32'(MemRead), 32'd1);
    check_eq("first_fetch_state", 32'(state), 32'd0);
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
    model_instret = '0;
    repeat (3) @(negedge clock);
    mem_ready = 1'b1;
    #1;
    check_eq("reset_state", 32'(state), 32'd0);
    check_eq("reset_instret", 32'(instret), 32'd0);
    check_eq("reset_ctrl", 32'(obs_ctrl), 32'd0);
    release_reset();

    run_instr(K_R, 6'h00, 6'h20, 0, 0, -1, 2);      // add $3,$1,$2
    run_instr(K_LW, 6'h23, 6'h04, 2, 3, -1, 2);     // lw with memory waits
    run_instr(K_BNE, 6'h05, 6'h00, 0, 0, -1, 1);    // bne, zero=1: not taken
    run_instr(K_BNE, 6'h05, 6'h00, 0, 0, -1, 0);    // bne, zero=0: taken
    run_instr(K_ORI, 6'h0D, 6'h0F, 0, 0, -1, 2);    // ori 0x34220F0F
    run_instr(K_ILLOP, 6'h3F, 6'h00, 0, 0, -1, 2);  // unsupported opcode
    run_instr(K_JR, 6'h00, 6'h08, 1, 0, -1, 2);
    run_instr(K_ILLFN, 6'h00, 6'h3F, 0, 0, -1, 2);

    run_random(150);

    // Store aborted by reset while waiting in MEMWR (path index 3).
    run_instr(K_SW, 6'h2B, 6'h00, 0, 3, 3, 2);
    release_reset();
    run_random(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle control sequencer for the MIPS core. It replaces the single-cycle opcode decoder with a Moore state machine. The machine steps a shared datapath (one memory, one ULA, instruction register, ALUOut/MDR registers) through fetch, decode, execute, memory and write-back. Memory accesses use a ready handshake, so the memory may have any latency. The block also keeps a retired-instruction counter and flags unsupported opcodes.

## Interface
- `COUNT_W`, default 32: width of `instret`.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: IR[31:26] from the instruction register.
- `funct` in 6: IR[5:0].
- `zero` in 1: ULA Zero_Flag.
- `mem_ready` in 1: memory completed the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA` out 1 each: datapath controls.
- `ALUSrcB` out 2: selects the second ULA operand.
  - 00 = B register
  - 01 = constant 4
  - 10 = extended immediate
  - 11 = extended immediate << 2
- `ALUOp` out 2: same coding as `ula_ctrl`.
  - 00 = ADD
  - 01 = SUB
  - 10 = funct
  - 11 = immediate logic
- `PCSource` out 2: selects the next PC.
  - 00 = ULA result
  - 01 = ALUOut
  - 10 = jump target
  - 11 = rs
- `BranchNe` out 1: when 1, PCWriteCond uses ~zero instead of zero.
- `ExtOp`, `JalEn`, `LuiEn` out 1 each: same meaning as in the single-cycle controller.
- `illegal` out 1: one-cycle pulse when an unsupported opcode or funct is decoded.
- `state` out 4: current state, for debug.
- `instret` out `COUNT_W`: count of retired instructions.

## Operation
- Control outputs are Moore outputs, decoded from `state` only. Any output not listed for a state is 0. `ExtOp` defaults to 1.
- **FETCH (0):**
  - Asserts `MemRead`, `IorD=0`, `ALUSrcA=0`, `ALUSrcB=01`, `ALUOp=00`, `PCSource=00`.
  - `IRWrite` and `PCWrite` are asserted only in the cycle where `mem_ready=1`. They are gated combinationally with `mem_ready`.
  - Moves to DECODE on `mem_ready`; otherwise stays.
- **DECODE (1):**
  - Asserts `ALUSrcA=0`, `ALUSrcB=11`, `ALUOp=00`, which computes the branch target into ALUOut.
  - Next state by opcode:
    - 100011 and 101011 (LW/SW): MEMADR.
    - 000000: JR if funct=001000; RTYPE_EX if funct is a supported ULA funct; otherwise ILLEGAL.
    - 000100 and 000101 (BEQ/BNE): BRANCH.
    - 001000, 001100, 001101, 001110 (ADDI/ANDI/ORI/XORI): IMM_EX.
    - 000010 (J): JUMP.
    - 000011 (JAL): JAL.
    - 001111 (LUI): LUI_WB.
    - Any other opcode: ILLEGAL.
- **MEMADR (2):** `ALUSrcA=1`, `ALUSrcB=10`. Goes to MEMRD if opcode=LW, else MEMWR.
- **MEMRD (3):** `MemRead`, `IorD=1`. Holds until `mem_ready`, then MEMWB.
- **MEMWB (4):** `RegWrite`, `MemtoReg`, `RegDst=0`. Retires, then FETCH.
- **MEMWR (5):** `MemWrite`, `IorD=1`. Holds until `mem_ready`, then retires and goes to FETCH.
- **RTYPE_EX (6):** `ALUSrcA=1`, `ALUSrcB=00`, `ALUOp=10`. Then RTYPE_WB.
- **RTYPE_WB (7):** `RegWrite`, `RegDst=1`. Retires, then FETCH.
- **BRANCH (8):**
  - Asserts `ALUSrcA=1`, `ALUSrcB=00`, `ALUOp=01`, `PCWriteCond`, `PCSource=01`.
  - `BranchNe=1` when opcode=000101.
  - Retires, then FETCH.
- **JUMP (9):** `PCWrite`, `PCSource=10`. Retires, then FETCH.
- **IMM_EX (10):**
  - Asserts `ALUSrcA=1`, `ALUSrcB=10`.
  - For ADDI: `ALUOp=00`, `ExtOp=1`.
  - For ANDI/ORI/XORI: `ALUOp=11`, `ExtOp=0`.
  - Then IMM_WB.
- **IMM_WB (11):** `RegWrite`, `RegDst=0`, `MemtoReg=0`. Keeps the same `ExtOp`/`ALUOp` as IMM_EX. Retires, then FETCH.
- **JAL (12):** `RegWrite`, `JalEn`, `PCWrite`, `PCSource=10`. Retires, then FETCH.
- **JR (13):** `PCWrite`, `PCSource=11`. Retires, then FETCH.
- **LUI_WB (14):** `RegWrite`, `LuiEn`, `RegDst=0`. Retires, then FETCH.
- **ILLEGAL (15):**
  - `illegal=1` for exactly this cycle. All write enables are 0.
  - Goes to FETCH without retiring. The PC has already advanced by 4, so the instruction is skipped.
- **Retire:** `instret` increments by 1 on the clock edge that leaves a retiring state. It wraps modulo 2^`COUNT_W`.
- **`mem_ready` outside wait states:** ignored.

## Timing
- **While `reset` is high:**
  - `state=FETCH`, `instret=0`.
  - All control outputs are forced to 0, including `MemRead`, `ExtOp` and `illegal`.
- **After reset falls:** the first FETCH request appears in the same cycle, driven combinationally from state.
- **Latency with `mem_ready` tied high:**

  | Instruction | Cycles |
  |---|---|
  | R-type, immediate ops | 4 |
  | LW | 5 |
  | SW | 4 |
  | BEQ, BNE, J, JAL, JR, LUI | 3 |

- **Memory waits:** each cycle with `mem_ready=0` in FETCH, MEMRD or MEMWR adds one cycle.
- **Reset asserted mid-operation:**
  - The state returns to FETCH immediately. A pending write is not completed and `instret` is cleared.
  - The memory must treat the loss of `MemRead`/`MemWrite` as an abort.

## Test plan
- **R-type add:** reset released, `mem_ready=1`, add $3,$1,$2 (0x00221820).
  - `state` sequence: 0, 1, 6, 7, 0.
  - `RegWrite=1` and `RegDst=1` only in cycle 4; `instret`=1.
- **LW with waits:** lw (0x8C220004), `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEMRD.
  - Total 10 cycles.
  - `IRWrite`/`PCWrite` pulse exactly once; `instret`=1.
- **BNE:** zero=1 gives `PCWriteCond=1`, `BranchNe=1`, and the PC is not taken. Repeat with zero=0 and the PC is taken. Each takes 3 cycles.
- **ORI:** ori 0x34220F0F.
  - `ExtOp=0` and `ALUOp=11` in states 10 and 11.
- **Illegal opcode:** opcode 0x3F.
  - `illegal` pulses for 1 cycle in state 15.
  - No `RegWrite`/`MemWrite`; `instret` unchanged.
- **Reset mid-store:** `reset` asserted during MEMWR while `mem_ready=0`.
  - `MemWrite` drops in the same cycle.
  - `state=0`, `instret=0`; after release, FETCH resumes.
